// File: rtl/fb_line_reader.sv
// Scan-out line fetcher: pulls one 640-pixel, 8-bpp line from the non-drawing frame buffer
// into a ping-pong line buffer and serves pixels to the VGA path one cycle after pix_x.
module fb_line_reader #(
  parameter int          WORDS_PER_LINE = 40,
  parameter int          NUM_LINES      = 480,
  parameter logic [21:0] RDADDR_OFFSET0 = 22'h100000,
  parameter logic [21:0] RDADDR_OFFSET1 = 22'h200000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         line_req,
  input  logic [8:0]   line_num,
  input  logic         frame_flip,
  input  logic         sdram_wait,
  input  logic         sdram_ac,
  input  logic [127:0] sdram_rddata,
  output logic         sdram_rd,
  output logic [21:0]  sdram_addr,
  output logic         busy,
  output logic         done,
  output logic         overrun,
  input  logic [8:0]   disp_line,
  input  logic [9:0]   pix_x,
  output logic [7:0]   pixel
);

  localparam logic [8:0] LINE_LIMIT = 9'(NUM_LINES);
  localparam logic [5:0] LAST_WORD  = 6'(WORDS_PER_LINE - 1);
  localparam logic [6:0] BANK1_BASE = 7'(WORDS_PER_LINE);
  localparam logic [9:0] PIX_LIMIT  = 10'd640;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_REQ  = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t       state, state_nxt;
  logic [5:0]   word, word_nxt;
  logic [21:0]  addr_nxt;
  logic         bank, bank_nxt;
  logic         overrun_nxt;
  logic [21:0]  line_off;
  logic [6:0]   wr_idx;
  logic [6:0]   rd_idx;
  logic         pix_valid;
  logic [127:0] rd_word;
  logic         unused_disp;

  logic [127:0] linebuf [0:2*WORDS_PER_LINE-1];

  // line_num * 40 as (line_num << 5) + (line_num << 3)
  assign line_off    = {8'd0, line_num, 5'd0} + {10'd0, line_num, 3'd0};
  assign wr_idx      = (bank ? BANK1_BASE : 7'd0) + {1'b0, word};
  assign pix_valid   = (pix_x < PIX_LIMIT);
  assign rd_idx      = pix_valid ? ((disp_line[0] ? BANK1_BASE : 7'd0) + {1'b0, pix_x[9:4]}) : 7'd0;
  assign rd_word     = linebuf[rd_idx];
  assign unused_disp = ^disp_line[8:1];

  // Next-state, address and word-counter logic for the fetch FSM
  always_comb begin
    state_nxt   = state;
    word_nxt    = word;
    addr_nxt    = sdram_addr;
    bank_nxt    = bank;
    overrun_nxt = overrun;
    case (state)
      S_IDLE: begin
        if (line_req) begin
          if (line_num < LINE_LIMIT) begin
            bank_nxt  = line_num[0];
            addr_nxt  = (frame_flip ? RDADDR_OFFSET0 : RDADDR_OFFSET1) + line_off;
            word_nxt  = 6'd0;
            state_nxt = sdram_wait ? S_WAIT : S_REQ;
          end else begin
            overrun_nxt = 1'b1;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!sdram_wait) begin
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_REQ: begin
        if (sdram_ac) begin
          state_nxt = S_NEXT;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_NEXT: begin
        if (word == LAST_WORD) begin
          state_nxt = S_DONE;
        end else begin
          word_nxt  = word + 6'd1;
          addr_nxt  = sdram_addr + 22'd1;
          state_nxt = sdram_wait ? S_WAIT : S_REQ;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // A request that arrives while a line is in flight is lost, not queued
    if (line_req && (state != S_IDLE)) begin
      overrun_nxt = 1'b1;
    end else begin
      overrun_nxt = overrun_nxt;
    end
  end

  // FSM state and registered outputs decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      word       <= 6'd0;
      bank       <= 1'b0;
      sdram_addr <= 22'd0;
      sdram_rd   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      word       <= word_nxt;
      bank       <= bank_nxt;
      sdram_addr <= addr_nxt;
      sdram_rd   <= (state_nxt == S_REQ);
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_DONE);
      overrun    <= overrun_nxt;
    end
  end

  // Line buffer write port; contents are not reset
  always_ff @(posedge clk) begin
    if ((state == S_REQ) && sdram_ac) begin
      linebuf[wr_idx] <= sdram_rddata;
    end
  end

  // Registered pixel read, blank beyond the visible width
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel <= 8'h00;
    end else if (pix_valid) begin
      pixel <= rd_word[{pix_x[3:0], 3'b000} +: 8];
    end else begin
      pixel <= 8'h00;
    end
  end

endmodule

// File: tb/tb_fb_line_reader.sv
// Directed bench for fb_line_reader: the bench plays the SDRAM arbiter and checks
// fetch addresses, handshake timing, overrun behaviour and the pixel read path.
module tb_fb_line_reader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         line_req = 1'b0;
  logic [8:0]   line_num = 9'd0;
  logic         frame_flip = 1'b0;
  logic         sdram_wait = 1'b0;
  logic         sdram_ac = 1'b0;
  logic [127:0] sdram_rddata = 128'd0;
  logic         sdram_rd;
  logic [21:0]  sdram_addr;
  logic         busy;
  logic         done;
  logic         overrun;
  logic [8:0]   disp_line = 9'd0;
  logic [9:0]   pix_x = 10'd0;
  logic [7:0]   pixel;

  int checks = 0;
  int failures = 0;

  fb_line_reader dut (
    .clk(clk), .reset(reset), .line_req(line_req), .line_num(line_num),
    .frame_flip(frame_flip), .sdram_wait(sdram_wait), .sdram_ac(sdram_ac),
    .sdram_rddata(sdram_rddata), .sdram_rd(sdram_rd), .sdram_addr(sdram_addr),
    .busy(busy), .done(done), .overrun(overrun), .disp_line(disp_line),
    .pix_x(pix_x), .pixel(pixel)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: every byte = addr[7:0]; mode 1: byte n = addr[7:0] + 3n
  function automatic logic [7:0] pat_byte(input logic [21:0] a, input int n, input int mode);
    if (mode == 0) return a[7:0];
    return a[7:0] + 8'(n * 3);
  endfunction

  function automatic logic [127:0] pat(input logic [21:0] a, input int mode);
    logic [127:0] d;
    for (int n = 0; n < 16; n++) d[8*n +: 8] = pat_byte(a, n, mode);
    return d;
  endfunction

  task automatic pix_check(input string tag, input int x, input int dl, input logic [7:0] exp);
    @(negedge clk);
    disp_line = 9'(dl);
    pix_x = 10'(x);
    @(negedge clk);
    check_eq(tag, {24'd0, pixel}, {24'd0, exp});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one line request and act as the SDRAM arbiter until done (or abort)
  task automatic run_line(input int ln, input bit flip, input int mode,
                          input int wword, input int wcyc, input int aword, input int adel,
                          input int req_at, input int flip_at, input int abort_word,
                          input int exp_done);
    logic [21:0] base, exp_addr;
    int acks, dly, wleft, rd_cycles, addr_err, wait_err, done_cnt, done_cyc;
    bit prev_wait, fin;
    base = flip ? 22'h100000 : 22'h200000;
    acks = 0; dly = 0; wleft = 0; rd_cycles = 0; addr_err = 0; wait_err = 0;
    done_cnt = 0; done_cyc = -1; prev_wait = 1'b0; fin = 1'b0;
    @(negedge clk);
    sdram_wait = 1'b0;
    sdram_ac = 1'b0;
    line_req = 1'b1;
    line_num = 9'(ln);
    frame_flip = flip;
    for (int c = 1; c <= 400 && !fin; c++) begin
      @(negedge clk);
      line_req = 1'b0;
      sdram_ac = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = c;
      end
      if (prev_wait && sdram_rd) wait_err++;
      if (abort_word >= 0 && acks == abort_word && sdram_rd) begin
        reset = 1'b1;
        #1;
        check_eq("abort_rd", {31'd0, sdram_rd}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (wleft > 0) begin
        wleft--;
        if (wleft == 0) sdram_wait = 1'b0;
      end
      if (sdram_rd) begin
        rd_cycles++;
        exp_addr = base + 22'(ln * 40) + 22'(acks);
        if (sdram_addr !== exp_addr) addr_err++;
        if (acks == aword && dly < adel) begin
          dly++;
        end else begin
          sdram_ac = 1'b1;
          sdram_rddata = pat(sdram_addr, mode);
          acks++;
          if (acks == wword) begin
            sdram_wait = 1'b1;
            wleft = wcyc;
          end
        end
      end
      if (c == req_at) begin
        line_req = 1'b1;
        line_num = 9'(ln + 1);
      end
      if (c == flip_at) frame_flip = ~frame_flip;
      prev_wait = sdram_wait;
      if (done_cnt > 0 && c == done_cyc + 1) fin = 1'b1;
    end
    check_eq("done_cycle", 32'(done_cyc), 32'(exp_done));
    check_eq("done_count", 32'(done_cnt), 32'd1);
    check_eq("words_acked", 32'(acks), 32'd40);
    check_eq("rd_cycles", 32'(rd_cycles), 32'(40 + adel));
    check_eq("addr_errors", 32'(addr_err), 32'd0);
    check_eq("rd_during_wait", 32'(wait_err), 32'd0);
    check_eq("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_rd", {31'd0, sdram_rd}, 32'd0);
    check_eq("rst_addr", {10'd0, sdram_addr}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    check_eq("rst_pixel", {24'd0, pixel}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Line 3 from buffer 1 into bank 1, minimum timing
    run_line(3, 1'b0, 0, -1, 0, -1, 0, -1, -1, -1, 81);
    pix_check("l3_x0", 0, 1, 8'h78);
    pix_check("l3_x8", 8, 1, 8'h78);
    pix_check("l3_x639", 639, 1, 8'h9F);

    // Line 0 from buffer 0 with frame_flip toggled mid-fetch; fills bank 0 with {16{w}}
    run_line(0, 1'b1, 0, -1, 0, -1, 0, -1, 20, -1, 81);
    for (int x = 0; x <= 640; x++) begin
      pix_check("sweep", x, 0, (x < 640) ? 8'(x >> 4) : 8'h00);
    end

    // Line 5 with a 5-cycle wait before word 10 and ac delayed 3 cycles on word 20
    run_line(5, 1'b0, 1, 10, 5, 20, 3, -1, -1, -1, 88);
    pix_check("l5_x0", 0, 1, 8'hC8);
    pix_check("l5_x15", 15, 1, 8'hF5);
    pix_check("l5_x327", 327, 1, 8'hF1);
    pix_check("l5_x639", 639, 1, 8'h1C);
    pix_check("l5_x700", 700, 1, 8'h00);

    // Request dropped mid-fetch; fetch still completes
    check_eq("ovr_before", {31'd0, overrun}, 32'd0);
    run_line(7, 1'b0, 0, -1, 0, -1, 0, 40, -1, -1, 81);
    check_eq("ovr_midfetch", {31'd0, overrun}, 32'd1);
    repeat (4) @(negedge clk);
    check_eq("ovr_sticky", {31'd0, overrun}, 32'd1);
    do_reset();
    check_eq("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Out-of-range line in Idle
    @(negedge clk);
    line_req = 1'b1;
    line_num = 9'd480;
    @(negedge clk);
    line_req = 1'b0;
    check_eq("ovr_480", {31'd0, overrun}, 32'd1);
    check_eq("busy_480", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("rd_480", {31'd0, sdram_rd}, 32'd0);
    check_eq("ovr_480_sticky", {31'd0, overrun}, 32'd1);
    do_reset();

    // Reset at word 25, then a fresh fetch from word 0
    run_line(9, 1'b0, 0, -1, 0, -1, 0, -1, -1, 25, 81);
    check_eq("post_abort_ovr", {31'd0, overrun}, 32'd0);
    run_line(9, 1'b0, 0, -1, 0, -1, 0, -1, -1, -1, 81);
    pix_check("l9_x0", 0, 1, 8'h68);
    pix_check("l9_x639", 639, 1, 8'h8F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
